// File: rtl/exception_unit.sv
// exception_unit: multicycle exception sequencer feeding the exception/PC-source mux.
// Detects invalid-opcode, overflow and divide-by-zero events, saves EPC, fetches the
// handler vector byte from memory and issues a one-cycle redirect with exc_taken.
// Optional feature macro: EXC_MASK_EN adds the exc_mask[2:0] input
// (bit0 = opcode, bit1 = overflow, bit2 = div0); a masked cause is treated as absent.
module exception_unit #(
  parameter int unsigned MEM_LATENCY = 1,   // cycles from mem_rd to valid mem_rdata (1..15)
  parameter int unsigned VEC_BASE    = 253, // byte address of the invalid-opcode vector
  parameter int unsigned EPC_OFFSET  = 4    // subtracted from pc_in to form EPC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
`ifdef EXC_MASK_EN
  input  logic [2:0]  exc_mask,
`endif
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] epc,
  output logic        epc_write,
  output logic [1:0]  exc_cause,
  output logic [7:0]  exc_byte,
  output logic        ex_sel,
  output logic        pc_write,
  output logic        busy,
  output logic        exc_taken
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE     = 3'd1,
    ADDR     = 3'd2,
    WAIT     = 3'd3,
    LOAD     = 3'd4,
    REDIRECT = 3'd5
  } state_t;

  // WAIT is entered with this count and leaves for LOAD when the count reaches zero,
  // so WAIT lasts exactly MEM_LATENCY cycles.
  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic [31:0] epc_reg;
  logic [31:0] addr_reg;
  logic [1:0]  cause_reg;
  logic [7:0]  byte_reg;

  logic [2:0]  raw_events;
  logic [2:0]  live_events;
  logic [1:0]  cause_sel;

  // Only the low byte of the memory word carries the vector.
  logic        unused_rdata_bits;
  assign unused_rdata_bits = ^mem_rdata[31:8];

  assign raw_events = {exc_div0, exc_overflow, exc_opcode};

`ifdef EXC_MASK_EN
  assign live_events = raw_events & ~exc_mask;
`else
  assign live_events = raw_events;
`endif

  // Resolve the highest-priority enabled cause: opcode > overflow > div0.
  always_comb begin
    cause_sel = 2'd0;
    if (live_events[0])      cause_sel = 2'd1;
    else if (live_events[1]) cause_sel = 2'd2;
    else if (live_events[2]) cause_sel = 2'd3;
  end

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic and strobes decoded purely from the current state.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    epc_write  = 1'b0;
    mem_rd     = 1'b0;
    ex_sel     = 1'b0;
    pc_write   = 1'b0;
    exc_taken  = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (cause_sel != 2'd0) state_next = SAVE;
      end
      SAVE: begin
        epc_write  = 1'b1;
        state_next = ADDR;
      end
      ADDR: begin
        mem_rd     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = LOAD;
      end
      LOAD: begin
        state_next = REDIRECT;
      end
      REDIRECT: begin
        ex_sel     = 1'b1;
        pc_write   = 1'b1;
        exc_taken  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: cause latch, EPC, vector address, latency counter, vector byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_reg <= 2'd0;
      epc_reg   <= 32'd0;
      addr_reg  <= 32'd0;
      cnt_reg   <= 4'd0;
      byte_reg  <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cause_sel != 2'd0) cause_reg <= cause_sel;
        end
        SAVE: begin
          epc_reg  <= pc_in - EPC_OFFSET;
          // Address is registered here so it is already stable while mem_rd is high.
          addr_reg <= VEC_BASE + {30'd0, cause_reg} - 32'd1;
        end
        ADDR: begin
          cnt_reg <= LAT_INIT;
        end
        WAIT: begin
          if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
        end
        LOAD: begin
          byte_reg <= mem_rdata[7:0];
        end
        REDIRECT: begin
          // Address is only meaningful during the fetch; clear it on the way back to IDLE.
          addr_reg <= 32'd0;
        end
        default: begin
          addr_reg <= 32'd0;
        end
      endcase
    end
  end

  assign epc       = epc_reg;
  assign mem_addr  = addr_reg;
  assign exc_cause = cause_reg;
  assign exc_byte  = byte_reg;

endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: randomized self-checking bench for exception_unit.
// Two instances are built (MEM_LATENCY = 1 and 3) and exercised one at a time.
// Expected behaviour comes from a timeline model: an accepted event at cycle N yields
// epc_write at N+1, mem_rd at N+2 and the redirect at N+4+MEM_LATENCY.
module tb_exception_unit;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]        reset_n;
  logic [NI-1:0]        exc_opcode, exc_overflow, exc_div0;
  logic [NI-1:0][2:0]   exc_mask;
  logic [NI-1:0][31:0]  pc_in, mem_rdata, mem_addr, epc;
  logic [NI-1:0]        mem_rd, epc_write, ex_sel, pc_write, busy, exc_taken;
  logic [NI-1:0][1:0]   exc_cause;
  logic [NI-1:0][7:0]   exc_byte;

  int vectors = 0;
  int errors  = 0;

  // Values the model expects to be held in IDLE between exceptions.
  logic [1:0]  hold_cause [NI];
  logic [7:0]  hold_byte  [NI];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      exception_unit #(
        .MEM_LATENCY((gi == 0) ? 1 : 3),
        .VEC_BASE   (253),
        .EPC_OFFSET (4)
      ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n[gi]),
        .exc_opcode  (exc_opcode[gi]),
        .exc_overflow(exc_overflow[gi]),
        .exc_div0    (exc_div0[gi]),
`ifdef EXC_MASK_EN
        .exc_mask    (exc_mask[gi]),
`endif
        .pc_in       (pc_in[gi]),
        .mem_rdata   (mem_rdata[gi]),
        .mem_addr    (mem_addr[gi]),
        .mem_rd      (mem_rd[gi]),
        .epc         (epc[gi]),
        .epc_write   (epc_write[gi]),
        .exc_cause   (exc_cause[gi]),
        .exc_byte    (exc_byte[gi]),
        .ex_sel      (ex_sel[gi]),
        .pc_write    (pc_write[gi]),
        .busy        (busy[gi]),
        .exc_taken   (exc_taken[gi])
      );
    end
  endgenerate

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Cause number of the first enabled event in priority order (index 0 = opcode).
  function automatic logic [1:0] ref_cause(logic [2:0] ev, logic [2:0] m);
    for (int i = 0; i < 3; i++)
      if (ev[i] && !m[i]) return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic set_events(int d, logic [2:0] ev);
    exc_opcode[d]   = ev[0];
    exc_overflow[d] = ev[1];
    exc_div0[d]     = ev[2];
  endtask

  task automatic check_idle_regs(string tag, int d);
    check({tag, " busy"},      32'(busy[d]),      32'd0);
    check({tag, " epc_write"}, 32'(epc_write[d]), 32'd0);
    check({tag, " mem_rd"},    32'(mem_rd[d]),    32'd0);
    check({tag, " ex_sel"},    32'(ex_sel[d]),    32'd0);
    check({tag, " exc_taken"}, 32'(exc_taken[d]), 32'd0);
    check({tag, " exc_cause"}, 32'(exc_cause[d]), 32'(hold_cause[d]));
    check({tag, " exc_byte"},  32'(exc_byte[d]),  32'(hold_byte[d]));
  endtask

  // One exception attempt, entered and left at 1 time unit after a rising edge.
  // noise: 0 = events dropped after cycle N, 1 = random events while busy,
  //        2 = original events held high until the redirect cycle.
  task automatic txn(string name, int d, logic [2:0] ev, logic [2:0] m_in,
                     logic [31:0] pc, logic [31:0] mword, int noise);
    logic [2:0]  m;
    logic [2:0]  r;
    logic [1:0]  cause;
    int          lat, last;
    string       tag;
    m = m_in;
`ifndef EXC_MASK_EN
    m = 3'b000;
`endif
    lat   = lat_of(d);
    last  = 4 + lat;
    cause = ref_cause(ev, m);
    set_events(d, ev);
    exc_mask[d]  = m;
    pc_in[d]     = pc;
    mem_rdata[d] = $urandom;
    if (cause == 2'd0) begin
      @(posedge clk); #1;
      set_events(d, 3'b000);
      check_idle_regs($sformatf("%s/d%0d/none", name, d), d);
      $display("txn %s dut%0d lat=%0d events=%b mask=%b: no exception taken", name, d, lat, ev, m);
      return;
    end
    for (int k = 1; k <= last + 1; k++) begin
      @(posedge clk); #1;
      tag = $sformatf("%s/d%0d/N+%0d", name, d, k);
      check({tag, " busy"},      32'(busy[d]),      32'(k <= last));
      check({tag, " epc_write"}, 32'(epc_write[d]), 32'(k == 1));
      check({tag, " mem_rd"},    32'(mem_rd[d]),    32'(k == 2));
      check({tag, " ex_sel"},    32'(ex_sel[d]),    32'(k == last));
      check({tag, " pc_write"},  32'(pc_write[d]),  32'(k == last));
      check({tag, " exc_taken"}, 32'(exc_taken[d]), 32'(k == last));
      check({tag, " exc_cause"}, 32'(exc_cause[d]), 32'(cause));
      if (k >= 2 && k <= last)
        check({tag, " mem_addr"}, mem_addr[d], 32'd253 + 32'(cause) - 32'd1);
      if (k >= last) begin
        check({tag, " epc"},      epc[d],             pc - 32'd4);
        check({tag, " exc_byte"}, 32'(exc_byte[d]),   32'(mword[7:0]));
      end
      // Memory answers MEM_LATENCY cycles after the ADDR cycle; garbage before that.
      mem_rdata[d] = (k >= 2 + lat) ? mword : $urandom;
      if (k <= last && noise == 1) begin
        r = 3'($urandom);
        set_events(d, r);
      end else if (k <= last && noise == 2) begin
        set_events(d, ev);
      end else begin
        set_events(d, 3'b000);
      end
    end
    hold_cause[d] = cause;
    hold_byte[d]  = mword[7:0];
    $display("txn %s dut%0d lat=%0d events=%b mask=%b pc=%08h -> cause=%0d epc=%08h byte=%02h",
             name, d, lat, ev, m, pc, cause, pc - 32'd4, mword[7:0]);
  endtask

  // Overflow accepted, then reset asserted while the sequencer sits in WAIT.
  task automatic reset_mid_wait(int d);
    string tag;
    set_events(d, 3'b010);
    exc_mask[d] = 3'b000;
    pc_in[d]    = 32'h0000_1000;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      set_events(d, 3'b000);
    end
    tag = $sformatf("rst_wait/d%0d", d);
    check({tag, " busy_before"}, 32'(busy[d]), 32'd1);
    reset_n[d] = 1'b0;
    #1;
    check({tag, " busy"},      32'(busy[d]),      32'd0);
    check({tag, " ex_sel"},    32'(ex_sel[d]),    32'd0);
    check({tag, " epc"},       epc[d],            32'd0);
    check({tag, " exc_cause"}, 32'(exc_cause[d]), 32'd0);
    check({tag, " exc_byte"},  32'(exc_byte[d]),  32'd0);
    check({tag, " mem_addr"},  mem_addr[d],       32'd0);
    check({tag, " pc_write"},  32'(pc_write[d]),  32'd0);
    @(negedge clk);
    reset_n[d] = 1'b1;
    hold_cause[d] = 2'd0;
    hold_byte[d]  = 8'd0;
    @(posedge clk); #1;
    check_idle_regs({tag, " after"}, d);
    $display("txn rst_wait dut%0d: reset asserted in WAIT", d);
  endtask

  initial begin
    logic [2:0]  ev;
    logic [2:0]  m;
    logic [31:0] pc;
    int          d;
    reset_n      = '0;
    exc_opcode   = '0;
    exc_overflow = '0;
    exc_div0     = '0;
    exc_mask     = '0;
    pc_in        = '0;
    mem_rdata    = '0;
    for (int i = 0; i < NI; i++) begin
      hold_cause[i] = 2'd0;
      hold_byte[i]  = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check_idle_regs($sformatf("reset/d%0d", i), i);
      check($sformatf("reset/d%0d epc", i),      epc[i],      32'd0);
      check($sformatf("reset/d%0d mem_addr", i), mem_addr[i], 32'd0);
    end
    @(negedge clk);
    reset_n = '1;
    @(posedge clk); #1;

    // Directed cases.
    txn("ovf_0x40",     0, 3'b010, 3'b000, 32'h0000_0040, 32'h0000_007C, 0);
    txn("op_div0",      0, 3'b101, 3'b000, 32'h0000_0100, 32'h5555_5511, 2);
    txn("div0_noisy",   0, 3'b100, 3'b000, 32'h0000_2000, 32'h0000_00E3, 1);
    txn("idle_hold",    0, 3'b000, 3'b000, 32'h0000_3000, 32'h0000_0000, 0);
    txn("ovf_lat3",     1, 3'b010, 3'b000, 32'h0000_0040, 32'hABCD_EF12, 0);
    txn("pc_zero",      0, 3'b001, 3'b000, 32'h0000_0000, 32'h0000_0099, 1);
    txn("pc_zero_lat3", 1, 3'b100, 3'b000, 32'h0000_0000, 32'h1234_5680, 1);
`ifdef EXC_MASK_EN
    txn("mask_op",      0, 3'b011, 3'b001, 32'h0000_0500, 32'h0000_0042, 0);
    txn("mask_all",     0, 3'b111, 3'b111, 32'h0000_0600, 32'h0000_0000, 0);
`endif
    reset_mid_wait(1);
    txn("after_rst",    1, 3'b001, 3'b000, 32'h0000_0800, 32'h0000_00C7, 0);

    // Randomized traffic across both latencies.
    for (int i = 0; i < 60; i++) begin
      d  = i % 2;
      ev = 3'($urandom);
      m  = 3'($urandom);
      if ($urandom_range(0, 3) == 0) m = 3'b000;
      pc = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      txn("random", d, ev, m, pc, 32'($urandom), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
